// File: rtl/pc_sequencer_if.sv
// Bus between the program-counter sequencer and its environment
// (instruction memory, datapath and ALU flags).
interface pc_sequencer_if;
  logic        start;
  logic        fetch_req;
  logic        fetch_ack;
  logic [5:0]  instr_opcode;
  logic [31:0] instr_target;
  logic        exec_done;
  logic        flag_we;
  logic        alu_zero;
  logic        alu_sign;
  logic        alu_carry;
  logic [31:0] pc;
  logic        taken;
  logic        halted;
  logic [15:0] taken_cnt;

  // Handshake: fetch_req stays high for the whole FETCH state; fetch_ack is
  // only honoured while fetch_req is high. exec_done is only honoured in EXEC.
  modport master (
    input  start, fetch_ack, instr_opcode, instr_target, exec_done,
    input  flag_we, alu_zero, alu_sign, alu_carry,
    output fetch_req, pc, taken, halted, taken_cnt
  );

  modport slave (
    output start, fetch_ack, instr_opcode, instr_target, exec_done,
    output flag_we, alu_zero, alu_sign, alu_carry,
    input  fetch_req, pc, taken, halted, taken_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute/update sequencer that owns the program counter,
// the ALU flag register and a saturating taken-branch counter.
module pc_sequencer (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [5:0] OP_HALT = 6'b111111;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [5:0]  op_r_q, op_r_d;
  logic [31:0] tgt_r_q, tgt_r_d;
  logic [2:0]  flags_q, flags_d;   // {fz, fs, fc}
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic        fetch_req_q, fetch_req_d;
  logic        taken_q, taken_d;
  logic        halted_q, halted_d;

  function automatic logic branch_take(input logic [5:0] op, input logic [2:0] f);
    logic fz, fs, fc;
    {fz, fs, fc} = f;
    case (op)
      6'b101011, 6'b101000, 6'b100000: branch_take = 1'b1;
      6'b110001: branch_take = fz;
      6'b110010: branch_take = ~fz;
      6'b110000: branch_take = fs;
      6'b101001: branch_take = fc;
      6'b101010: branch_take = ~fc;
      default:   branch_take = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    op_r_d      = op_r_q;
    tgt_r_d     = tgt_r_q;
    flags_d     = flags_q;
    taken_cnt_d = taken_cnt_q;
    taken_d     = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.fetch_ack) begin
          op_r_d  = bus.instr_opcode;
          tgt_r_d = bus.instr_target;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = (op_r_q == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (bus.flag_we) flags_d = {bus.alu_zero, bus.alu_sign, bus.alu_carry};
        // Decide the branch here from flags_d so a same-cycle flag load is seen.
        if (bus.exec_done) begin
          state_d = S_UPDATE;
          taken_d = branch_take(op_r_q, flags_d);
        end
      end
      S_UPDATE: begin
        pc_d = taken_q ? tgt_r_q : pc_q + 32'd4;
        if (taken_q && taken_cnt_q != 16'hFFFF) taken_cnt_d = taken_cnt_q + 16'd1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    fetch_req_d = (state_d == S_FETCH);
    halted_d    = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= 32'd0;
      op_r_q      <= 6'd0;
      tgt_r_q     <= 32'd0;
      flags_q     <= 3'd0;
      taken_cnt_q <= 16'd0;
      fetch_req_q <= 1'b0;
      taken_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      op_r_q      <= op_r_d;
      tgt_r_q     <= tgt_r_d;
      flags_q     <= flags_d;
      taken_cnt_q <= taken_cnt_d;
      fetch_req_q <= fetch_req_d;
      taken_q     <= taken_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.fetch_req = fetch_req_q;
  assign bus.pc        = pc_q;
  assign bus.taken     = taken_q;
  assign bus.halted    = halted_q;
  assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential flow, conditional branches,
// halt, reset mid-fetch, counter saturation and pc wrap.
module tb_pc_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.start        = 1'b0;
    bus.fetch_ack    = 1'b0;
    bus.instr_opcode = 6'd0;
    bus.instr_target = 32'd0;
    bus.exec_done    = 1'b0;
    bus.flag_we      = 1'b0;
    bus.alu_zero     = 1'b0;
    bus.alu_sign     = 1'b0;
    bus.alu_carry    = 1'b0;
  endtask

  // Starts in FETCH, ends back in FETCH after UPDATE. Flags are written in the
  // same EXEC cycle that exec_done arrives.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [31:0] tgt,
                           input logic we, input logic z, input logic s, input logic c,
                           input logic exp_taken);
    bus.fetch_ack = 1'b1; bus.instr_opcode = op; bus.instr_target = tgt;
    tick();
    bus.fetch_ack = 1'b0;
    tick();
    bus.exec_done = 1'b1; bus.flag_we = we;
    bus.alu_zero = z; bus.alu_sign = s; bus.alu_carry = c;
    tick();
    chk({tag, "_taken_in_update"}, 32'(bus.taken), 32'(exp_taken));
    clear_inputs();
    tick();
    chk({tag, "_back_to_fetch"}, 32'(dut.state_q), 32'd1);
    chk({tag, "_taken_pulse_end"}, 32'(bus.taken), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    chk("rst_state", 32'(dut.state_q), 32'd0);
    chk("rst_pc", bus.pc, 32'd0);
    chk("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
    chk("rst_taken", 32'(bus.taken), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_cnt", 32'(bus.taken_cnt), 32'd0);
    tick();
    chk("idle_hold", 32'(dut.state_q), 32'd0);

    // Sequential instruction, ack after 3 cycles of waiting
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("seq_fetch_req", 32'(bus.fetch_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seq_wait_fetch", 32'(bus.fetch_req), 32'd1);
    end
    bus.fetch_ack = 1'b1; bus.instr_opcode = 6'b000001; bus.instr_target = 32'hDEAD0000;
    tick();
    bus.fetch_ack = 1'b0;
    chk("seq_decode", 32'(dut.state_q), 32'd2);
    chk("seq_req_drop", 32'(bus.fetch_req), 32'd0);
    tick();
    chk("seq_exec", 32'(dut.state_q), 32'd3);
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    chk("seq_update", 32'(dut.state_q), 32'd4);
    chk("seq_taken", 32'(bus.taken), 32'd0);
    chk("seq_pc_before", bus.pc, 32'd0);
    tick();
    chk("seq_pc", bus.pc, 32'd4);
    chk("seq_refetch", 32'(bus.fetch_req), 32'd1);
    chk("seq_taken_after", 32'(bus.taken), 32'd0);

    // Conditional taken with same-cycle flag load
    run_instr("bz", 6'b110001, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("bz_pc", bus.pc, 32'h100);
    chk("bz_cnt", 32'(bus.taken_cnt), 32'd1);

    // Set fc=1, then flag_we outside EXEC must be ignored
    run_instr("setc", 6'b000010, 32'h5000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("setc_pc", bus.pc, 32'h104);
    bus.flag_we = 1'b1;
    tick();
    bus.flag_we = 1'b0;
    run_instr("bnc", 6'b101010, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bnc_pc", bus.pc, 32'h108);
    chk("bnc_cnt", 32'(bus.taken_cnt), 32'd1);
    run_instr("bc", 6'b101001, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bc_pc", bus.pc, 32'h300);
    chk("bc_cnt", 32'(bus.taken_cnt), 32'd2);

    // Halt is absorbing
    bus.fetch_ack = 1'b1; bus.instr_opcode = 6'b111111; bus.instr_target = 32'h777;
    tick();
    bus.fetch_ack = 1'b0;
    tick();
    chk("halt_state", 32'(dut.state_q), 32'd5);
    chk("halt_flag", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      bus.start = 1'b1; bus.fetch_ack = 1'b1; bus.exec_done = 1'b1;
      tick();
      chk("halt_pc", bus.pc, 32'h300);
      chk("halt_hold", 32'(bus.halted), 32'd1);
    end
    clear_inputs();
    chk("halt_no_req", 32'(bus.fetch_req), 32'd0);

    // Reset out of HALT, run one branch, then reset mid-fetch with ack pending
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("halt_rst_state", 32'(dut.state_q), 32'd0);
    chk("halt_rst_halted", 32'(bus.halted), 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_instr("bra", 6'b101000, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bra_pc", bus.pc, 32'h40);
    bus.fetch_ack = 1'b1; bus.instr_opcode = 6'b110010; bus.instr_target = 32'h1234;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mf_state", 32'(dut.state_q), 32'd0);
    chk("mf_pc", bus.pc, 32'd0);
    chk("mf_req", 32'(bus.fetch_req), 32'd0);
    chk("mf_op", 32'(dut.op_r_q), 32'd0);
    chk("mf_tgt", dut.tgt_r_q, 32'd0);
    chk("mf_cnt", 32'(bus.taken_cnt), 32'd0);
    tick();
    clear_inputs();
    chk("mf_stay_idle", 32'(dut.state_q), 32'd0);

    // Saturation and wrap, counter preloaded near full
    dut.taken_cnt_q <= 16'hFFFE;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("sat_preload", 32'(bus.taken_cnt), 32'h0000FFFE);
    run_instr("sat1", 6'b101011, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sat1_cnt", 32'(bus.taken_cnt), 32'h0000FFFF);
    chk("sat1_pc", bus.pc, 32'hFFFFFFFC);
    run_instr("sat2", 6'b100000, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sat2_cnt", 32'(bus.taken_cnt), 32'h0000FFFF);
    chk("sat2_pc", bus.pc, 32'hFFFFFFFC);
    run_instr("wrap", 6'b000000, 32'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_pc", bus.pc, 32'd0);
    chk("wrap_cnt", 32'(bus.taken_cnt), 32'h0000FFFF);

    // Sign branch, then not-zero branch relying on persisted fz=0
    run_instr("bs", 6'b110000, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("bs_pc", bus.pc, 32'h80);
    run_instr("bnz", 6'b110010, 32'h90, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("bnz_pc", bus.pc, 32'h90);
    run_instr("bz_nt", 6'b110001, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bz_nt_pc", bus.pc, 32'h94);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
